// File: rtl/fifo_stream_pkg.sv
// ============================================================================
// Module      : fifo_stream_pkg
// Description : Shared FSM encoding and credit limit for the FIFO stream reader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Buffered words + in-flight reads + a new strobe must never exceed this.
    localparam logic [1:0] c_CREDIT_LIMIT = 2'd2;

endpackage : fifo_stream_pkg

`default_nettype wire

// File: rtl/stream_skid_buf.sv
// ============================================================================
// Module      : stream_skid_buf
// Description : 2-entry output buffer; the head entry drives the registered stream outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_skid_buf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_valid;
    logic                  w_pop;

    assign w_pop = r_out_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
        end else if (w_pop) begin
            // Head leaves: promote the skid entry first so order is preserved.
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_skid_valid <= i_valid;
                if (i_valid) begin
                    r_skid_data <= i_data;
                end
            end else begin
                r_out_valid <= i_valid;
                if (i_valid) begin
                    r_out_data <= i_data;
                end
            end
        end else if (i_valid) begin
            if (!r_out_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= i_data;
            end else begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= i_data;
            end
        end
    end

    assign o_data  = r_out_data;
    assign o_valid = r_out_valid;
    assign o_count = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

endmodule : stream_skid_buf

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// Module      : fifo_stream_reader
// Description : Reads FIFO words in bursts or flush drains and presents them as a stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 10,
    parameter int BURST_LEN   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_empty,
    input  logic [COUNT_WIDTH-1:0] fifo_rd_count,
    input  logic                   flush,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy
);

    localparam logic [COUNT_WIDTH-1:0] c_BURST_LEN = COUNT_WIDTH'(BURST_LEN);

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_beat_cnt;
    logic                   r_inflight;
    logic                   r_flush_pend;

    logic [1:0]             w_occ;
    logic [1:0]             w_occ_after;
    logic                   w_pop;
    logic                   w_credit;
    logic                   w_rd_en;

    // A word accepted this cycle frees its slot in time for a new strobe,
    // which is what sustains one word per cycle with only two slots.
    always_comb begin
        w_pop       = m_valid & m_ready;
        w_occ_after = w_occ - {1'b0, w_pop};
        w_credit    = (w_occ_after + {1'b0, r_inflight}) < c_CREDIT_LIMIT;
        w_rd_en     = 1'b0;
        if (!rst && !fifo_empty && w_credit) begin
            case (r_state)
                ST_BURST: w_rd_en = (r_beat_cnt != '0);
                ST_FLUSH: w_rd_en = 1'b1;
                default:  w_rd_en = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_inflight   <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            case (r_state)
                ST_IDLE: begin
                    r_flush_pend <= 1'b0;
                    if (flush) begin
                        r_state <= ST_FLUSH;
                    end else if (fifo_rd_count >= c_BURST_LEN) begin
                        r_state    <= ST_BURST;
                        r_beat_cnt <= c_BURST_LEN;
                    end
                end
                ST_BURST: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (w_rd_en) begin
                        r_beat_cnt <= (r_beat_cnt != '0) ? r_beat_cnt - 1'b1 : '0;
                    end
                    if ((r_beat_cnt == '0) && !r_inflight) begin
                        r_state      <= (r_flush_pend || flush) ? ST_FLUSH : ST_IDLE;
                        r_flush_pend <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty && !r_inflight && !w_rd_en) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture is gated by the in-flight flag, so data returning after a reset is dropped.
    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_inflight),
        .i_data  (fifo_rd_data),
        .i_ready (m_ready),
        .o_data  (m_data),
        .o_valid (m_valid),
        .o_count (w_occ)
    );

    assign fifo_rd_en = w_rd_en;
    assign busy       = (r_state != ST_IDLE);

endmodule : fifo_stream_reader

`default_nettype wire

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the width of FIFO read data and stream data.
REQ-002 Parameter COUNT_WIDTH, default 10, sets the width of the FIFO read-side occupancy count.
REQ-003 Parameter BURST_LEN, default 16, sets the words per burst; legal range 1 .. 2**COUNT_WIDTH-1.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1 bit: the single clock; all logic samples on the rising edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port fifo_rd_en, output, 1 bit: read strobe to the FIFO read side.
REQ-008 Port fifo_rd_data, input, DATA_WIDTH bits: FIFO read data, valid one cycle after fifo_rd_en.
REQ-009 Port fifo_empty, input, 1 bit: FIFO read-side empty flag.
REQ-010 Port fifo_rd_count, input, COUNT_WIDTH bits: FIFO read-side occupancy.
REQ-011 Port flush, input, 1 bit: single-cycle pulse requesting a drain of all remaining words.
REQ-012 Port m_data, output, DATA_WIDTH bits: stream data.
REQ-013 Port m_valid, output, 1 bit: stream data valid.
REQ-014 Port m_ready, input, 1 bit: downstream accept.
REQ-015 Port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, BURST and FLUSH.
REQ-017 IDLE -> FLUSH SHALL occur on flush=1; flush SHALL take priority over a burst start.
REQ-018 IDLE -> BURST SHALL occur on fifo_rd_count >= BURST_LEN; this loads beat_cnt with BURST_LEN.
REQ-019 BURST SHALL assert fifo_rd_en only when fifo_empty=0, beat_cnt>0 and credit is available; each strobe decrements beat_cnt by 1.
REQ-020 BURST -> IDLE SHALL occur when beat_cnt=0 and no read is in flight.
REQ-021 A flush pulse seen in BURST SHALL be latched; on completion of the burst the FSM SHALL go to FLUSH instead of IDLE.
REQ-022 FLUSH SHALL strobe whenever fifo_empty=0 and credit is available.
REQ-023 FLUSH -> IDLE SHALL occur when fifo_empty=1, no read is in flight, and no strobe is issued in that cycle.
REQ-024 Credit rule: output-buffer occupancy + in-flight reads + the new strobe SHALL never exceed 2.
REQ-025 The output buffer SHALL be a 2-entry skid buffer; returned data SHALL be captured on the cycle after the strobe without loss.
REQ-026 m_data and m_valid SHALL be registered outputs.
REQ-027 m_data SHALL be held stable while m_valid=1 and m_ready=0.
REQ-028 A transfer SHALL occur when m_valid=1 and m_ready=1.
REQ-029 Word order on the stream SHALL equal FIFO read order; no word SHALL be duplicated or dropped.
REQ-030 With m_ready held at 1 and data available, throughput SHALL be 1 word/cycle.
REQ-031 Latency from the first strobe to m_valid=1 SHALL be 2 cycles.
REQ-032 Simultaneous capture and accept SHALL leave buffer occupancy unchanged.
REQ-033 fifo_rd_en SHALL never be asserted while fifo_empty=1.
REQ-034 beat_cnt SHALL be COUNT_WIDTH bits, SHALL saturate at 0 and SHALL never wrap.

Reset
REQ-035 On rst=1 at a clock edge, state SHALL become IDLE and all outputs SHALL be 0: fifo_rd_en=0, m_valid=0, m_data=0, busy=0.
REQ-036 On reset, beat_cnt, buffer occupancy, in-flight state and the latched flush SHALL be cleared.
REQ-037 A reset mid-burst SHALL discard buffered and in-flight words.
REQ-038 Data returning from the FIFO on the cycle after reset SHALL be ignored.

Structure
REQ-039 The state encoding and credit limit (2) SHALL be constants in shared package fifo_stream_pkg.
REQ-040 The output buffer SHALL be one sub-module, stream_skid_buf, parameterised by DATA_WIDTH; the FSM and credit logic SHALL stay in the top module.

Verification
REQ-041 Burst: preload 20 words 0x00..0x13, BURST_LEN=16, m_ready=1 -> 16 words 0x00..0x0F on consecutive cycles, then IDLE with 4 words left.
REQ-042 Backpressure: m_ready toggled 1/0 every cycle during a burst -> no loss or duplication, m_data stable while stalled, at most 2 strobes outstanding.
REQ-043 Flush: 5 words in the FIFO, flush pulse -> words 0..4 on the stream, then busy=0 and no strobe while fifo_empty=1.
REQ-044 Flush during burst: flush at beat 8 of 16 with 30 words in the FIFO -> 16 burst words, then FLUSH drains the remaining 14, in order.
REQ-045 Reset mid-burst: rst=1 at beat 6 -> next cycle m_valid=0, fifo_rd_en=0, busy=0; a new burst starts cleanly at the next word.
REQ-046 Boundary: fifo_rd_count=15 with BURST_LEN=16 -> no strobe; count becomes 16 -> burst starts on the next cycle.
